// File: rtl/triangle_raster_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : raster_pkg                                                     |
// | Shared screen geometry, controller state codes and min/max helpers for   |
// | the triangle raster sequencer and its bounding-box unit.                 |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package raster_pkg;

   localparam int COORD_W = 9;
   localparam int H_RES   = 320;
   localparam int V_RES   = 240;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_BBOX  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b,
                                               input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b,
                                               input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/triangle_raster_ctrl_tri_bbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tri_bbox                                                       |
// | Combinational bounding box of three vertices, with the maximum corner    |
// | clamped to the last visible pixel. 'empty' flags a box that lies wholly  |
// | off-screen after clamping.                                               |
// | Ports   : ax..cy (in)  vertex coordinates                                |
// |           xmin, xmax, ymin, ymax (out) clamped box, empty (out)          |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tri_bbox
   import raster_pkg::*;
#(
   parameter int X_RES = 320,
   parameter int Y_RES = 240
) (
   input  logic [COORD_W-1:0] ax,
   input  logic [COORD_W-1:0] ay,
   input  logic [COORD_W-1:0] bx,
   input  logic [COORD_W-1:0] by,
   input  logic [COORD_W-1:0] cx,
   input  logic [COORD_W-1:0] cy,
   output logic [COORD_W-1:0] xmin,
   output logic [COORD_W-1:0] xmax,
   output logic [COORD_W-1:0] ymin,
   output logic [COORD_W-1:0] ymax,
   output logic               empty
);

   localparam logic [COORD_W-1:0] C_X_LIM = COORD_W'(X_RES - 1);
   localparam logic [COORD_W-1:0] C_Y_LIM = COORD_W'(Y_RES - 1);

   logic [COORD_W-1:0] w_xmax_raw;
   logic [COORD_W-1:0] w_ymax_raw;

   assign xmin       = min3(ax, bx, cx);
   assign ymin       = min3(ay, by, cy);
   assign w_xmax_raw = max3(ax, bx, cx);
   assign w_ymax_raw = max3(ay, by, cy);

   // Only the far corner is clamped; a near corner beyond the screen edge
   // makes the box inverted, which is exactly the empty condition.
   assign xmax  = (w_xmax_raw > C_X_LIM) ? C_X_LIM : w_xmax_raw;
   assign ymax  = (w_ymax_raw > C_Y_LIM) ? C_Y_LIM : w_ymax_raw;
   assign empty = (xmin > xmax) || (ymin > ymax);

endmodule
`default_nettype wire

// File: rtl/triangle_raster_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : triangle_raster_ctrl                                           |
// | Sweeps the clamped bounding box of one triangle in raster order through  |
// | the external point-in-triangle datapath and issues one framebuffer write |
// | per pixel (or per inside pixel) over a valid/ready handshake.            |
// | Ports   : CLOCK_50, reset (sync, active-high)                            |
// |           start, ax..cy          triangle request and vertices           |
// |           tri_ax..tri_cy, px, py  latched vertices / point to datapath   |
// |           check                  datapath inside result                  |
// |           pix_valid/ready, pix_x/y, pix_in   framebuffer write port      |
// |           busy, done, inside_cnt status                                  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module triangle_raster_ctrl #(
   parameter int COORD_W       = raster_pkg::COORD_W,
   parameter int H_RES         = raster_pkg::H_RES,
   parameter int V_RES         = raster_pkg::V_RES,
   parameter int TEST_LAT      = 2,
   parameter bit WRITE_OUTSIDE = 1'b1
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               start,
   input  logic [COORD_W-1:0] ax,
   input  logic [COORD_W-1:0] ay,
   input  logic [COORD_W-1:0] bx,
   input  logic [COORD_W-1:0] by,
   input  logic [COORD_W-1:0] cx,
   input  logic [COORD_W-1:0] cy,
   output logic [COORD_W-1:0] tri_ax,
   output logic [COORD_W-1:0] tri_ay,
   output logic [COORD_W-1:0] tri_bx,
   output logic [COORD_W-1:0] tri_by,
   output logic [COORD_W-1:0] tri_cx,
   output logic [COORD_W-1:0] tri_cy,
   output logic [COORD_W-1:0] px,
   output logic [COORD_W-1:0] py,
   input  logic               check,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic               pix_in,
   output logic               busy,
   output logic               done,
   output logic [16:0]        inside_cnt
);
   import raster_pkg::*;

   localparam int              C_CNT_W   = (TEST_LAT > 1) ? $clog2(TEST_LAT) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TEST_LAT - 1);
   localparam logic [16:0]     C_INS_MAX = '1;

   logic [2:0]         r_state;
   logic [COORD_W-1:0] r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
   logic [COORD_W-1:0] r_px, r_py;
   logic [COORD_W-1:0] r_xmin, r_xmax, r_ymax;
   logic [C_CNT_W-1:0] r_cnt;
   logic               r_pix_in;
   logic [16:0]        r_inside_cnt;

   logic [COORD_W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
   logic               w_empty;
   logic               w_sample;
   logic               w_hit;
   logic               w_adv;

   tri_bbox #(
      .X_RES (H_RES),
      .Y_RES (V_RES)
   ) u_bbox (
      .ax    (r_ax),
      .ay    (r_ay),
      .bx    (r_bx),
      .by    (r_by),
      .cx    (r_cx),
      .cy    (r_cy),
      .xmin  (w_xmin),
      .xmax  (w_xmax),
      .ymin  (w_ymin),
      .ymax  (w_ymax),
      .empty (w_empty)
   );

   // check is trusted only on the last wait cycle of a pixel.
   assign w_sample = (r_state == S_WAIT) && (r_cnt == C_CNT_LAST);
   assign w_hit    = WRITE_OUTSIDE || check;
   // Move to the next pixel: a skipped pixel, or a write accepted this cycle.
   assign w_adv    = (w_sample && !w_hit) || ((r_state == S_WRITE) && pix_ready);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_ax         <= '0;
         r_ay         <= '0;
         r_bx         <= '0;
         r_by         <= '0;
         r_cx         <= '0;
         r_cy         <= '0;
         r_px         <= '0;
         r_py         <= '0;
         r_xmin       <= '0;
         r_xmax       <= '0;
         r_ymax       <= '0;
         r_cnt        <= '0;
         r_pix_in     <= 1'b0;
         r_inside_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_ax         <= ax;
                  r_ay         <= ay;
                  r_bx         <= bx;
                  r_by         <= by;
                  r_cx         <= cx;
                  r_cy         <= cy;
                  r_inside_cnt <= '0;
                  r_state      <= S_BBOX;
               end
            end
            S_BBOX: begin
               r_xmin <= w_xmin;
               r_xmax <= w_xmax;
               r_ymax <= w_ymax;
               if (w_empty) begin
                  r_state <= S_DONE;
               end else begin
                  r_px    <= w_xmin;
                  r_py    <= w_ymin;
                  r_cnt   <= '0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_sample) begin
                  r_pix_in <= check;
                  if (check && (r_inside_cnt != C_INS_MAX)) begin
                     r_inside_cnt <= r_inside_cnt + 17'd1;
                  end
                  if (w_hit) begin
                     r_state <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               r_state <= S_WRITE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         // Raster advance, x inner; overrides the state update above.
         if (w_adv) begin
            if (r_px < r_xmax) begin
               r_px    <= r_px + 1'b1;
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end else if (r_py < r_ymax) begin
               r_px    <= r_xmin;
               r_py    <= r_py + 1'b1;
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end else begin
               r_state <= S_DONE;
            end
         end
      end
   end

   assign tri_ax     = r_ax;
   assign tri_ay     = r_ay;
   assign tri_bx     = r_bx;
   assign tri_by     = r_by;
   assign tri_cx     = r_cx;
   assign tri_cy     = r_cy;
   assign px         = r_px;
   assign py         = r_py;
   assign pix_valid  = (r_state == S_WRITE);
   assign pix_x      = r_px;
   assign pix_y      = r_py;
   assign pix_in     = r_pix_in;
   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_DONE);
   assign inside_cnt = r_inside_cnt;

endmodule
`default_nettype wire
